// File: rtl/fir_pkg.sv
// Shared defaults and host-sequencer state encoding for the FIR host-side path.
package fir_pkg;

  localparam int ADDR_W_DEF      = 10;
  localparam int DATA_W_DEF      = 8;
  localparam int N_SAMPLES_DEF   = 64;
  localparam int RESULT_BASE_DEF = 512;
  localparam int TIMEOUT_DEF     = 4095;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DRAIN
  } host_state_t;

endpackage

// File: rtl/fir_skid_buf.sv
// Two-entry valid/ready buffer on the result drain path; exposes its occupancy
// so the read issuer can hold back reads it would have no room for.
module fir_skid_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] data_q [2];
  logic [DATA_W-1:0] data_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              push, pop;

  assign pop  = out_ready && (count_q != 2'd0);
  // When full, a simultaneous pop frees the very slot the write targets.
  assign push = in_valid && ((count_q != 2'd2) || pop);

  always_comb begin
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    if (push) data_d[wr_ptr_q] = in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q   <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = data_q[rd_ptr_q];
  assign occupancy = count_q;

endmodule

// File: rtl/fir_host_ctrl.sv
// Host-side sequencer for fir_top: loads samples through port B, starts the
// filter, waits for done (with timeout) and streams results out of port A.
module fir_host_ctrl import fir_pkg::*; #(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int N_SAMPLES   = N_SAMPLES_DEF,
  parameter int RESULT_BASE = RESULT_BASE_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              sel_pipelined_in,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              mem_own,
  output logic [ADDR_W-1:0] mem_addr_b,
  output logic              mem_we_b,
  output logic [DATA_W-1:0] mem_data_in_b,
  output logic [ADDR_W-1:0] mem_addr_a,
  input  logic [DATA_W-1:0] mem_data_out_a,
  output logic              fir_start,
  output logic              fir_sel_pipelined,
  input  logic              fir_done,
  output logic              busy,
  output logic              error,
  output logic [15:0]       run_cycles
);

  localparam logic [ADDR_W-1:0] N_CNT  = ADDR_W'(N_SAMPLES);
  localparam logic [ADDR_W-1:0] N_LAST = ADDR_W'(N_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(RESULT_BASE);

  host_state_t       state_q, state_d;
  logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic              inflight_q, inflight_d;
  logic [15:0]       run_cycles_q, run_cycles_d, run_cycles_inc;
  logic              sel_q, sel_d;
  logic              error_q, error_d;

  logic              accept, issue, pop, skid_valid;
  logic [1:0]        skid_occ;
  logic [2:0]        credit_used;
  logic [DATA_W-1:0] skid_data;

  // Counting the same-cycle pop lets a freed slot be re-requested at once,
  // which is what sustains one result per cycle with a two-entry buffer.
  assign pop            = skid_valid && m_ready;
  assign credit_used    = {1'b0, skid_occ} + {2'b0, inflight_q} - {2'b0, pop};
  assign accept         = (state_q == ST_LOAD) && s_valid;
  assign issue          = (state_q == ST_DRAIN) && (rd_idx_q != N_CNT) && (credit_used < 3'd2);
  assign run_cycles_inc = (run_cycles_q == 16'hFFFF) ? run_cycles_q : run_cycles_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    inflight_d   = issue;
    run_cycles_d = run_cycles_q;
    sel_d        = sel_q;
    error_d      = error_q;
    if (issue) rd_idx_d = rd_idx_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d      = ST_LOAD;
          sel_d        = sel_pipelined_in;
          error_d      = 1'b0;
          wr_idx_d     = '0;
          rd_idx_d     = '0;
          run_cycles_d = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wr_idx_d = wr_idx_q + 1'b1;
          if (wr_idx_q == N_LAST) state_d = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        run_cycles_d = run_cycles_inc;
        if (fir_done) begin
          state_d = ST_DRAIN;
        end else if ({16'd0, run_cycles_inc} >= 32'(TIMEOUT)) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // Last beat: every read issued, none in flight, only it left buffered.
        if (pop && (rd_idx_q == N_CNT) && !inflight_q && (skid_occ == 2'd1))
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      inflight_q   <= 1'b0;
      run_cycles_q <= '0;
      sel_q        <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      inflight_q   <= inflight_d;
      run_cycles_q <= run_cycles_d;
      sel_q        <= sel_d;
      error_q      <= error_d;
    end
  end

  fir_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inflight_q),
    .in_data   (mem_data_out_a),
    .out_valid (skid_valid),
    .out_data  (skid_data),
    .out_ready (m_ready),
    .occupancy (skid_occ)
  );

  assign s_ready           = (state_q == ST_LOAD);
  assign mem_own           = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign mem_we_b          = accept;
  assign mem_addr_b        = (state_q == ST_LOAD) ? wr_idx_q : '0;
  assign mem_data_in_b     = accept ? s_data : '0;
  assign mem_addr_a        = (state_q == ST_DRAIN) ? (BASE + rd_idx_q) : '0;
  assign fir_start         = (state_q == ST_START);
  assign fir_sel_pipelined = sel_q;
  assign busy              = (state_q != ST_IDLE);
  assign error             = error_q;
  assign run_cycles        = run_cycles_q;
  assign m_valid           = skid_valid;
  assign m_data            = skid_data;

endmodule

// File: tb/tb_fir_host_ctrl.sv
// Directed-plus-random bench for fir_host_ctrl with a sample/result memory model.
module tb_fir_host_ctrl;

  localparam int N  = 64;
  localparam int TO = 50;
  localparam int RB = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        sel_pipelined_in = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        s_ready;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready = 1'b0;
  logic        mem_own;
  logic [9:0]  mem_addr_b;
  logic        mem_we_b;
  logic [7:0]  mem_data_in_b;
  logic [9:0]  mem_addr_a;
  logic [7:0]  mem_data_out_a = 8'd0;
  logic        fir_start;
  logic        fir_sel_pipelined;
  logic        fir_done = 1'b0;
  logic        busy;
  logic        error;
  logic [15:0] run_cycles;

  fir_host_ctrl #(.TIMEOUT(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .run               (run),
    .sel_pipelined_in  (sel_pipelined_in),
    .s_valid           (s_valid),
    .s_data            (s_data),
    .s_ready           (s_ready),
    .m_valid           (m_valid),
    .m_data            (m_data),
    .m_ready           (m_ready),
    .mem_own           (mem_own),
    .mem_addr_b        (mem_addr_b),
    .mem_we_b          (mem_we_b),
    .mem_data_in_b     (mem_data_in_b),
    .mem_addr_a        (mem_addr_a),
    .mem_data_out_a    (mem_data_out_a),
    .fir_start         (fir_start),
    .fir_sel_pipelined (fir_sel_pipelined),
    .fir_done          (fir_done),
    .busy              (busy),
    .error             (error),
    .run_cycles        (run_cycles)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] samples [N];
  logic [7:0] res_mem [N];
  logic [7:0] mem [1024];
  int         we_count = 0;

  // Sample region is written by the DUT; the result region is supplied by the bench.
  always @(posedge clk) begin
    if (mem_we_b) begin
      mem[mem_addr_b] <= mem_data_in_b;
      we_count        <= we_count + 1;
    end
    if (int'(mem_addr_a) >= RB && int'(mem_addr_a) < RB + N)
      mem_data_out_a <= res_mem[int'(mem_addr_a) - RB];
    else
      mem_data_out_a <= 8'hEE;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic sel);
    @(negedge clk);
    s_valid = 1'b0; m_ready = 1'b0; fir_done = 1'b0;
    run = 1'b1; sel_pipelined_in = sel;
    @(negedge clk);
    run = 1'b0; sel_pipelined_in = ~sel;
    #1;
    chk("busy_after_run", busy, 1);
    chk("mem_own_after_run", mem_own, 1);
    chk("sel_latched", fir_sel_pipelined, sel);
    chk("error_cleared", error, 0);
    chk("run_cycles_cleared", run_cycles, 0);
  endtask

  task automatic load_samples(input bit throttle);
    int idx = 0;
    int cyc = 0;
    int we_start = we_count;
    int bad = 0;
    while (idx < N && cyc < 400) begin
      @(negedge clk);
      s_valid = throttle ? cyc[0] : 1'b1;
      s_data  = samples[idx];
      #1;
      chk("s_ready_load", s_ready, 1);
      chk("we_follows_valid", mem_we_b, s_valid);
      if (s_valid) begin
        chk("wr_addr", mem_addr_b, idx);
        chk("wr_data", mem_data_in_b, s_data);
        idx++;
      end
      cyc++;
    end
    chk("load_complete", idx, N);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    chk("write_count", we_count - we_start, N);
    for (int i = 0; i < N; i++) if (mem[i] !== samples[i]) bad++;
    chk("mem_contents", bad, 0);
    chk("fir_start_pulse", fir_start, 1);
    chk("s_ready_after_load", s_ready, 0);
  endtask

  task automatic wait_done(input int delay);
    for (int k = 1; k <= delay; k++) begin
      @(negedge clk);
      fir_done = (k == delay);
      #1;
      if (k == 1) begin
        chk("fir_start_single", fir_start, 0);
        chk("wait_mem_own", mem_own, 0);
      end
    end
    @(negedge clk);
    fir_done = 1'b0;
    #1;
    chk("run_cycles", run_cycles, delay);
    chk("drain_mem_own", mem_own, 1);
  endtask

  // random_ready=0 holds m_ready high and also checks the N+2 cycle drain time.
  task automatic drain(input bit random_ready);
    int         got = 0;
    int         c = 0;
    logic [7:0] prev = 8'd0;
    bit         stall = 1'b0;
    while (got < N && c < 1000) begin
      if (c > 0) @(negedge clk);
      m_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (c < 2) chk("m_valid_early", m_valid, 0);
      if (stall) begin
        chk("stall_valid_held", m_valid, 1);
        chk("stall_data_held", m_data, prev);
      end
      stall = m_valid && !m_ready;
      prev  = m_data;
      if (m_valid && m_ready) begin
        chk("m_data", m_data, res_mem[got]);
        got++;
      end
      c++;
    end
    chk("drain_count", got, N);
    if (!random_ready) chk("drain_cycles", c, N + 2);
    @(negedge clk);
    m_ready = 1'b0;
    #1;
    chk("idle_after_drain", busy, 0);
    chk("no_extra_result", m_valid, 0);
    chk("own_released", mem_own, 0);
  endtask

  initial begin
    int  d;
    int  n;
    bit  seen_valid;

    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_mem_own", mem_own, 0);
    chk("rst_mem_we_b", mem_we_b, 0);
    chk("rst_fir_start", fir_start, 0);
    chk("rst_fir_sel", fir_sel_pipelined, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_run_cycles", run_cycles, 0);
    chk("rst_addrs", {mem_addr_a, mem_addr_b}, 0);
    chk("rst_data", {m_data, mem_data_in_b}, 0);
    @(negedge clk);
    rst = 1'b1;

    // Run 1: fixed pattern, done after 20 cycles, random backpressure.
    for (int i = 0; i < N; i++) begin
      samples[i] = (i < 5) ? 8'd64 : ((i >= 10 && i <= 14) ? 8'd32 : 8'd0);
      res_mem[i] = 8'(i);
    end
    start_run(1'b1);
    load_samples(1'b0);
    wait_done(20);
    drain(1'b1);
    $display("run 1: pattern load, done after 20, random m_ready");

    // Run 2: throttled random load, random done delay, full-rate drain.
    for (int i = 0; i < N; i++) begin
      samples[i] = 8'($urandom);
      res_mem[i] = 8'($urandom);
    end
    d = $urandom_range(1, 40);
    start_run(1'b0);
    load_samples(1'b1);
    wait_done(d);
    drain(1'b0);
    $display("run 2: throttled load, done after %0d, m_ready held", d);

    // Run 3: no fir_done, expect timeout.
    for (int i = 0; i < N; i++) samples[i] = 8'($urandom);
    start_run(1'($urandom_range(0, 1)));
    load_samples(1'b0);
    n = 0;
    seen_valid = 1'b0;
    while (n < 200) begin
      @(negedge clk);
      #1;
      if (m_valid) seen_valid = 1'b1;
      if (!busy) break;
      n++;
    end
    chk("timeout_cycles", n, TO);
    chk("timeout_error", error, 1);
    chk("timeout_run_cycles", run_cycles, TO);
    chk("timeout_no_m_valid", seen_valid, 0);
    chk("timeout_own", mem_own, 0);
    @(negedge clk);
    fir_done = 1'b1;
    @(negedge clk);
    fir_done = 1'b0;
    #1;
    chk("done_ignored_idle", busy, 0);
    chk("error_holds", error, 1);
    $display("run 3: timeout after %0d wait cycles", n);

    // Run 4: reset during drain with two results buffered.
    for (int i = 0; i < N; i++) begin
      samples[i] = 8'($urandom);
      res_mem[i] = 8'($urandom);
    end
    start_run(1'b1);
    load_samples(1'b0);
    wait_done(5);
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("pending_before_reset", m_valid, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_m_valid", m_valid, 0);
    chk("reset_mem_own", mem_own, 0);
    chk("reset_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    $display("run 4: reset asserted mid-drain");

    // Run 5: normal run after the mid-run reset.
    for (int i = 0; i < N; i++) begin
      samples[i] = 8'($urandom);
      res_mem[i] = 8'($urandom);
    end
    d = $urandom_range(1, 45);
    start_run(1'b0);
    load_samples(1'b0);
    wait_done(d);
    drain(1'b1);
    $display("run 5: recovery run, done after %0d", d);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
